// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register file with an iterative multiply/divide sequencer (shift-add, restoring divide).
// One result bit per RUN cycle; sign fix-up and the HI/LO write happen in FIX.
module hilo_muldiv_ctrl #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  logic              op_mult,
   input  logic              op_multu,
   input  logic              op_div,
   input  logic              op_divu,
   input  logic              op_mfhi,
   input  logic              op_mflo,
   input  logic              op_mthi,
   input  logic              op_mtlo,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   output logic              stall,
   output logic              busy,
   output logic [DATA_W-1:0] hilo_rdata,
   output logic              div_zero,
   output logic [DATA_W-1:0] hi_q,
   output logic [DATA_W-1:0] lo_q
);

   localparam int unsigned CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e                r_state, w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_W-1:0]     r_hi, r_lo, r_opnd, r_rs;
   logic [2*DATA_W-1:0]   r_p;
   logic                  r_is_div, r_neg_q, r_neg_r;

   logic w_hilo_op, w_accept, w_start, w_signed_op, w_is_div_op;
   logic w_sel_mult, w_sel_multu, w_sel_div, w_sel_divu;
   logic w_sel_mthi, w_sel_mtlo, w_sel_mfhi, w_sel_mflo;
   logic [DATA_W-1:0]   w_rs_abs, w_rt_abs, w_p_hi, w_p_lo, w_quot_fix, w_rem_fix;
   logic [DATA_W:0]     w_sum, w_rem, w_sub;
   logic [2*DATA_W-1:0] w_mul_step, w_div_step, w_prod_fix;

   // Fixed priority: mult > multu > div > divu > mthi > mtlo > mfhi > mflo.
   always_comb begin
      w_sel_mult  = op_mult;
      w_sel_multu = ~op_mult & op_multu;
      w_sel_div   = ~op_mult & ~op_multu & op_div;
      w_sel_divu  = ~op_mult & ~op_multu & ~op_div & op_divu;
      w_sel_mthi  = ~op_mult & ~op_multu & ~op_div & ~op_divu & op_mthi;
      w_sel_mtlo  = ~op_mult & ~op_multu & ~op_div & ~op_divu & ~op_mthi & op_mtlo;
      w_sel_mfhi  = ~op_mult & ~op_multu & ~op_div & ~op_divu & ~op_mthi & ~op_mtlo & op_mfhi;
      w_sel_mflo  = ~op_mult & ~op_multu & ~op_div & ~op_divu & ~op_mthi & ~op_mtlo & ~op_mfhi
                    & op_mflo;
      w_hilo_op   = issue_valid & (op_mult | op_multu | op_div | op_divu |
                                   op_mthi | op_mtlo | op_mfhi | op_mflo);
      busy        = (r_state != StIdle);
      stall       = w_hilo_op & busy;
      w_accept    = w_hilo_op & ~busy;
      w_start     = w_accept & (w_sel_mult | w_sel_multu | w_sel_div | w_sel_divu);
      w_signed_op = w_sel_mult | w_sel_div;
      w_is_div_op = w_sel_div | w_sel_divu;
      w_rs_abs    = (w_signed_op & rs_data[DATA_W-1]) ? -rs_data : rs_data;
      w_rt_abs    = (w_signed_op & rt_data[DATA_W-1]) ? -rt_data : rt_data;
      hilo_rdata  = '0;
      if (w_accept & w_sel_mfhi) hilo_rdata = r_hi;
      else if (w_accept & w_sel_mflo) hilo_rdata = r_lo;
      div_zero    = (r_state == StFix) & r_is_div & (r_opnd == '0);
      hi_q        = r_hi;
      lo_q        = r_lo;
   end

   // r_p holds {partial product, multiplier} or {remainder, dividend/quotient}.
   always_comb begin
      w_p_hi     = r_p[2*DATA_W-1:DATA_W];
      w_p_lo     = r_p[DATA_W-1:0];
      w_sum      = {1'b0, w_p_hi} + (w_p_lo[0] ? {1'b0, r_opnd} : '0);
      w_mul_step = {w_sum, w_p_lo[DATA_W-1:1]};
      w_rem      = {w_p_hi, w_p_lo[DATA_W-1]};
      w_sub      = w_rem - {1'b0, r_opnd};
      // A borrow out of the trial subtraction means the divisor did not fit.
      w_div_step = {(w_sub[DATA_W] ? w_rem[DATA_W-1:0] : w_sub[DATA_W-1:0]),
                    w_p_lo[DATA_W-2:0], ~w_sub[DATA_W]};
      w_prod_fix = r_neg_q ? -r_p : r_p;
      w_quot_fix = r_neg_q ? -w_p_lo : w_p_lo;
      w_rem_fix  = r_neg_r ? -w_p_hi : w_p_hi;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (w_start) w_state_nxt = StRun;
         StRun:   if (r_cnt == CNT_MAX) w_state_nxt = StFix;
         StFix:   w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= StIdle;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_opnd   <= '0;
         r_rs     <= '0;
         r_p      <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_start) begin
                  r_cnt    <= '0;
                  r_rs     <= rs_data;
                  r_is_div <= w_is_div_op;
                  r_neg_q  <= w_signed_op & (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
                  r_neg_r  <= w_signed_op & rs_data[DATA_W-1];
                  r_opnd   <= w_is_div_op ? w_rt_abs : w_rs_abs;
                  r_p      <= {{DATA_W{1'b0}}, (w_is_div_op ? w_rs_abs : w_rt_abs)};
               end else if (w_accept & w_sel_mthi) begin
                  r_hi <= rs_data;
               end else if (w_accept & w_sel_mtlo) begin
                  r_lo <= rs_data;
               end
            end
            StRun: begin
               r_p   <= r_is_div ? w_div_step : w_mul_step;
               r_cnt <= r_cnt + CNT_W'(1);
            end
            StFix: begin
               if (r_is_div && (r_opnd == '0)) begin
                  r_hi <= r_rs;
                  r_lo <= '1;
               end else if (r_is_div) begin
                  r_hi <= w_rem_fix;
                  r_lo <= w_quot_fix;
               end else begin
                  {r_hi, r_lo} <= w_prod_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
